bram_stream_reader: RTL and testbench

- Read-side master for one port of the project's true dual-port BRAM (1-cycle read latency, ce/we/addr/d/q port style).
- On a start pulse, reads NUM consecutive words from BASE. Returns them in order on a valid/ready output stream.
- Full throughput under continuous ready; a 2-entry output FIFO absorbs backpressure.
- Sits between BRAM port 0 and downstream compute/DMA logic, as the counterpart to the write-side bench/master.

---
 rtl/bram_stream_reader.sv | 123 ++++++++++++
 tb/tb_bram_stream_reader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/bram_stream_reader.sv
// Read-side master for one BRAM port: streams NUM words starting at BASE
// onto a valid/ready output, buffered by a 2-entry FIFO for backpressure.
module bram_stream_reader #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 8,
   parameter int CWIDTH = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_i,
   input  logic [AWIDTH-1:0] base_addr_i,
   input  logic [CWIDTH-1:0] num_i,
   output logic              idle_o,
   output logic              run_o,
   output logic              done_o,
   output logic [AWIDTH-1:0] addr_o,
   output logic              ce_o,
   output logic              we_o,
   output logic [DWIDTH-1:0] d_o,
   input  logic [DWIDTH-1:0] q_i,
   output logic              m_valid_o,
   input  logic              m_ready_i,
   output logic [DWIDTH-1:0] m_data_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [AWIDTH-1:0] base_q, base_d;
   logic [CWIDTH-1:0] num_q, num_d;
   logic [CWIDTH-1:0] issue_cnt_q, issue_cnt_d;
   logic [CWIDTH-1:0] acc_cnt_q, acc_cnt_d;
   logic              inflight_q;
   logic [DWIDTH-1:0] fifo_mem_q [2];
   logic              wr_ptr_q, rd_ptr_q;
   logic [1:0]        fifo_cnt_q;

   logic              push, pop, issue;
   logic [2:0]        credit;

   assign push   = inflight_q;
   assign pop    = (fifo_cnt_q != 2'd0) && m_ready_i;
   // Occupancy after this edge, not counting a read issued now.
   assign credit = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign issue  = (state_q == S_RUN) && (issue_cnt_q < num_q) && (credit < 3'd2);

   assign ce_o      = issue;
   assign addr_o    = base_q + issue_cnt_q[AWIDTH-1:0];
   assign we_o      = 1'b0;
   assign d_o       = '0;
   assign idle_o    = (state_q == S_IDLE);
   assign run_o     = (state_q == S_RUN);
   assign done_o    = (state_q == S_DONE);
   assign m_valid_o = (fifo_cnt_q != 2'd0);
   assign m_data_o  = fifo_mem_q[rd_ptr_q];

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      num_d       = num_q;
      issue_cnt_d = issue_cnt_q;
      acc_cnt_d   = acc_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               base_d      = base_addr_i;
               num_d       = num_i;
               issue_cnt_d = '0;
               acc_cnt_d   = '0;
               state_d     = (num_i == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (issue) issue_cnt_d = issue_cnt_q + CWIDTH'(1);
            if (pop) begin
               acc_cnt_d = acc_cnt_q + CWIDTH'(1);
               if (acc_cnt_q == num_q - CWIDTH'(1)) state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         base_q      <= '0;
         num_q       <= '0;
         issue_cnt_q <= '0;
         acc_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         num_q       <= num_d;
         issue_cnt_q <= issue_cnt_d;
         acc_cnt_q   <= acc_cnt_d;
      end
   end

   // Push and pop may coincide when full: the slot being overwritten is the head leaving.
   always_ff @(posedge clk) begin
      if (reset) begin
         inflight_q <= 1'b0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         fifo_cnt_q <= 2'd0;
         for (int unsigned i = 0; i < 2; i++) fifo_mem_q[i] <= '0;
      end else begin
         assert (!(push && !pop && (fifo_cnt_q == 2'd2)));
         inflight_q <= issue;
         if (push) begin
            fifo_mem_q[wr_ptr_q] <= q_i;
            wr_ptr_q             <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, pop};
      end
   end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a 1-cycle-latency BRAM model.
module tb_bram_stream_reader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_i;
   logic [7:0]  base_addr_i;
   logic [8:0]  num_i;
   logic        idle_o, run_o, done_o;
   logic [7:0]  addr_o;
   logic        ce_o, we_o;
   logic [31:0] d_o;
   logic [31:0] q_i;
   logic        m_valid_o;
   logic        m_ready_i;
   logic [31:0] m_data_o;

   logic        p1_ce, p1_we;
   logic [7:0]  p1_addr;
   logic [31:0] p1_d;
   logic [31:0] mem [256];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bram_stream_reader #(.DWIDTH(32), .AWIDTH(8), .CWIDTH(9)) dut (
      .clk(clk), .reset(reset), .start_i(start_i), .base_addr_i(base_addr_i),
      .num_i(num_i), .idle_o(idle_o), .run_o(run_o), .done_o(done_o),
      .addr_o(addr_o), .ce_o(ce_o), .we_o(we_o), .d_o(d_o), .q_i(q_i),
      .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o)
   );

   // Port 0 reads for the DUT, port 1 is the bench's preload path.
   always @(posedge clk) begin
      if (ce_o) q_i <= mem[addr_o];
      if (p1_ce && p1_we) mem[p1_addr] <= p1_d;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // mode 0: ready held 1; mode 1: ready toggles; mode 2: 10-cycle stall after 3 words
   task automatic run_xfer(input logic [7:0] base, input logic [8:0] num, input int mode,
                           input int budget);
      int       issued, acc, dones, cyc, stall;
      logic     held, pop;
      logic [31:0] hdata;
      logic [7:0]  ea;
      issued = 0; acc = 0; dones = 0; cyc = 0; stall = 0; held = 1'b0; hdata = '0;
      start_i = 1'b1; base_addr_i = base; num_i = num; m_ready_i = 1'b1;
      tick;
      start_i = 1'b0;
      while (dones == 0 && cyc < budget) begin
         case (mode)
            1:       m_ready_i = (cyc % 2 == 0);
            2: begin
               if (acc >= 3 && stall < 10) begin
                  m_ready_i = 1'b0;
                  stall++;
               end else m_ready_i = 1'b1;
            end
            default: m_ready_i = 1'b1;
         endcase
         #1;
         if (done_o) begin
            dones++;
            chk("done_after_all", 32'(acc), 32'(num));
         end
         if (ce_o) begin
            ea = base + 8'(issued);
            chk("ce_in_range", 32'(issued < int'(num)), 32'd1);
            chk("addr", 32'(addr_o), 32'(ea));
            issued++;
         end
         if (held) begin
            chk("hold_valid", 32'(m_valid_o), 32'd1);
            chk("hold_data", m_data_o, hdata);
         end
         if (mode == 2 && stall == 10 && m_ready_i && acc < int'(num))
            chk("full_rate", 32'(m_valid_o), 32'd1);
         pop = m_valid_o && m_ready_i;
         if (pop) begin
            ea = base + 8'(acc);
            chk("data", m_data_o, 32'h100 + 32'(ea));
            acc++;
         end
         chk("occupancy", 32'((issued - acc) <= 2), 32'd1);
         held  = m_valid_o && !m_ready_i;
         hdata = m_data_o;
         tick;
         cyc++;
      end
      chk("done_seen", 32'(dones), 32'd1);
      chk("words_accepted", 32'(acc), 32'(num));
      chk("reads_issued", 32'(issued), 32'(num));
      chk("back_idle", 32'({idle_o, done_o, m_valid_o}), 32'b100);
   endtask

   initial begin
      reset = 1'b1; start_i = 1'b0; base_addr_i = '0; num_i = '0; m_ready_i = 1'b1;
      p1_ce = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_d = '0;
      for (int a = 0; a < 256; a++) begin
         p1_ce = 1'b1; p1_we = 1'b1; p1_addr = 8'(a); p1_d = 32'(a) + 32'h100;
         tick;
      end
      p1_ce = 1'b0; p1_we = 1'b0;

      chk("rst_idle", 32'({idle_o, run_o, done_o}), 32'b100);
      chk("rst_ce_valid", 32'({ce_o, m_valid_o}), 32'b00);
      chk("rst_addr", 32'(addr_o), 32'd0);
      chk("rst_data", m_data_o, 32'd0);
      chk("we_d_zero", 32'(we_o) | d_o, 32'd0);
      reset = 1'b0;
      tick;

      // base 01, num 2, ready high: exact cycle timing
      start_i = 1'b1; base_addr_i = 8'h01; num_i = 9'd2; m_ready_i = 1'b1;
      tick; start_i = 1'b0; #1;
      chk("t1_c1_run", 32'({idle_o, run_o}), 32'b01);
      chk("t1_c1_ce", 32'({ce_o, addr_o}), 32'h101);
      tick;
      chk("t1_c2_ce", 32'({ce_o, addr_o}), 32'h102);
      chk("t1_c2_valid", 32'(m_valid_o), 32'd0);
      tick;
      chk("t1_c3_valid", 32'(m_valid_o), 32'd1);
      chk("t1_c3_data", m_data_o, 32'h101);
      chk("t1_c3_ce", 32'(ce_o), 32'd0);
      tick;
      chk("t1_c4_valid", 32'(m_valid_o), 32'd1);
      chk("t1_c4_data", m_data_o, 32'h102);
      chk("t1_c4_done", 32'(done_o), 32'd0);
      tick;
      chk("t1_c5_done", 32'({done_o, m_valid_o, ce_o}), 32'b100);
      tick;
      chk("t1_c6_idle", 32'({idle_o, done_o}), 32'b10);

      run_xfer(8'h10, 9'd8, 1, 100);
      run_xfer(8'hFE, 9'd4, 0, 50);

      // num = 0: straight to DONE without touching the BRAM
      start_i = 1'b1; base_addr_i = 8'h40; num_i = 9'd0;
      tick; start_i = 1'b0; #1;
      chk("n0_done", 32'({done_o, run_o, ce_o, m_valid_o}), 32'b1000);
      tick;
      chk("n0_idle", 32'({idle_o, done_o, ce_o, m_valid_o}), 32'b1000);

      run_xfer(8'h40, 9'd16, 2, 200);

      // ignored start during RUN, then reset mid-transfer
      start_i = 1'b1; base_addr_i = 8'h30; num_i = 9'd4; m_ready_i = 1'b0;
      tick; start_i = 1'b0; #1;
      chk("r_c1_addr", 32'({ce_o, addr_o}), 32'h130);
      tick;
      start_i = 1'b1; base_addr_i = 8'h50; num_i = 9'd2; #1;
      chk("r_c2_addr", 32'({ce_o, addr_o}), 32'h131);
      tick;
      start_i = 1'b0; #1;
      chk("r_c3_stall", 32'({run_o, ce_o}), 32'b10);
      tick;
      m_ready_i = 1'b1; #1;
      chk("r_c4_data", m_data_o, 32'h130);
      chk("r_c4_ce", 32'({ce_o, addr_o}), 32'h132);
      tick; #1;
      chk("r_c5_data", m_data_o, 32'h131);
      chk("r_c5_run", 32'(run_o), 32'd1);
      reset = 1'b1;
      tick;
      chk("r_rst_state", 32'({idle_o, run_o, done_o}), 32'b100);
      chk("r_rst_stream", 32'({ce_o, m_valid_o}), 32'b00);
      chk("r_rst_data", m_data_o, 32'd0);
      reset = 1'b0;
      tick;
      chk("r_after_q", 32'({idle_o, m_valid_o, ce_o}), 32'b100);
      tick;
      chk("r_after_q2", 32'(m_valid_o), 32'd0);

      run_xfer(8'h20, 9'd3, 0, 50);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
